imem_ctrl: RTL and testbench

Instruction-memory controller that owns the 64-word instruction RAM and schedules its single write path between a clear sequencer and a streaming program loader. While the memory is being cleared or loaded, it holds the MIPS core stalled and returns NOPs on the fetch port. Once the last word is accepted, it releases the core. It lets a bench or boot path load successive test programs into a zeroed memory without restarting simulation.

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_ram.sv | 23 ++
 rtl/imem_ctrl.sv | 104 ++++++++++
 tb/tb_imem_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction-memory controller.
// The state enum is used by imem_ctrl.
package imem_pkg;

  localparam int          DEF_DEPTH = 64;
  localparam int          DEF_AW    = 6;
  localparam logic [31:0] DEF_NOP   = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module imem_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: clears the RAM, streams in a program,
// then releases the core. The fetch port reads NOP while the core is held.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int          DEPTH = DEF_DEPTH,
  parameter int          AW    = DEF_AW,
  parameter logic [31:0] NOP   = DEF_NOP
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic [AW-1:0] cpu_a,
  output logic [31:0]   cpu_rd,
  output logic          cpu_hold,
  output logic          busy,
  output logic [AW:0]   wcount,
  output logic          ovf
);

  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] clr_addr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [31:0]   ram_rd;
  logic          full;
  logic          start;

  assign full  = (wcount == FULL);
  assign start = load_start && (state == IDLE || state == RUN);

  // Words past a full memory are still handshaken (so ld_last can end the
  // load) but never written, so address 0 is never overwritten.
  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    waddr     = clr_addr;
    wdata     = '0;
    unique case (state)
      IDLE:  if (load_start) state_nxt = CLEAR;
      CLEAR: begin
        we = 1'b1;
        if (clr_addr == LAST_ADDR) state_nxt = LOAD;
      end
      LOAD: begin
        if (ld_valid) begin
          waddr = wcount[AW-1:0];
          wdata = ld_data;
          we    = !full;
          if (ld_last) state_nxt = RUN;
        end
      end
      RUN:   if (load_start) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      clr_addr <= '0;
      wcount   <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        clr_addr <= '0;
        wcount   <= '0;
        ovf      <= 1'b0;
      end else if (state == CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
      end else if (state == LOAD && ld_valid) begin
        if (full) ovf <= 1'b1;
        else      wcount <= wcount + 1'b1;
      end
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (cpu_a),
    .rdata (ram_rd)
  );

  assign ld_ready = (state == LOAD);
  assign busy     = (state == CLEAR) || (state == LOAD);
  assign cpu_hold = (state != RUN);
  assign cpu_rd   = cpu_hold ? NOP : ram_rd;

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: random programs are loaded and the whole
// memory image is compared against an array model built from the program.
module tb_imem_ctrl;
  import imem_pkg::*;

  localparam int D = 64;
  localparam int A = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [31:0]   ld_data = '0;
  logic          ld_last = 1'b0;
  logic [A-1:0]  cpu_a = '0;
  logic [31:0]   cpu_rd;
  logic          cpu_hold;
  logic          busy;
  logic [A:0]    wcount;
  logic          ovf;

  int tests = 0;
  int fails = 0;

  logic [31:0] prog[$];
  logic [31:0] exp_mem[D];
  int          exp_wcount;
  logic        exp_ovf;

  imem_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .cpu_a      (cpu_a),
    .cpu_rd     (cpu_rd),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .wcount     (wcount),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // Expected image after a load: cleared memory, then the first DEPTH words.
  task automatic model_load();
    for (int a = 0; a < D; a++)
      exp_mem[a] = (a < prog.size()) ? prog[a] : 32'h0;
    exp_wcount = (prog.size() > D) ? D : prog.size();
    exp_ovf    = (prog.size() > D);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom);
  endtask

  // Pulses load_start, then feeds prog until the core is released.
  task automatic run_load(input int pct, input int pulse_at, output int cycles);
    int   idx;
    logic v, xfer, exp_rdy;
    model_load();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    cycles = 0;
    idx = 0;
    while (cpu_hold === 1'b1 && cycles < 2000) begin
      v          = (idx < prog.size()) && ($urandom_range(99) < pct);
      ld_valid   = v;
      ld_data    = v ? prog[idx] : $urandom;
      ld_last    = v && (idx == prog.size() - 1);
      load_start = (cycles == pulse_at);
      cpu_a      = A'($urandom);
      #1;
      exp_rdy = (cycles >= D);
      tests++;
      if (ld_ready !== exp_rdy || busy !== 1'b1 || cpu_rd !== 32'h0) begin
        fails++;
        $display("[TB] FAIL held_cycle%0d: ld_ready=%b busy=%b cpu_rd=%h, want ld_ready=%b busy=1 cpu_rd=00000000",
                 cycles, ld_ready, busy, cpu_rd, exp_rdy);
      end
      xfer = v && ld_ready;
      @(posedge clk); cycles++; #1;
      if (xfer) idx++;
    end
    ld_valid = 1'b0; ld_last = 1'b0; load_start = 1'b0;
    tests++;
    if (cycles >= 2000) begin
      fails++;
      $display("[TB] FAIL load_timeout: cpu_hold=%b after %0d cycles, want 0", cpu_hold, cycles);
    end
    tests++;
    if (idx != prog.size()) begin
      fails++;
      $display("[TB] FAIL words_taken: %0d, want %0d", idx, prog.size());
    end
  endtask

  task automatic check_run(input string tag);
    #1;
    tests++;
    if (cpu_hold !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_run_flags: hold=%b busy=%b ld_ready=%b, want 0 0 0", tag, cpu_hold, busy, ld_ready);
    end
    tests++;
    if (wcount !== (A+1)'(exp_wcount) || ovf !== exp_ovf) begin
      fails++;
      $display("[TB] FAIL %s_counts: wcount=%0d ovf=%b, want wcount=%0d ovf=%b", tag, wcount, ovf, exp_wcount, exp_ovf);
    end
    for (int a = 0; a < D; a++) begin
      cpu_a = A'(a);
      #1;
      tests++;
      if (cpu_rd !== exp_mem[a]) begin
        fails++;
        $display("[TB] FAIL %s_mem[%0d]: got %h, want %h", tag, a, cpu_rd, exp_mem[a]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (5) begin
      @(posedge clk); #1;
      cpu_a = A'($urandom);
      #1;
      tests++;
      if (cpu_hold !== 1'b1 || cpu_rd !== 32'h0 || ld_ready !== 1'b0 || busy !== 1'b0 ||
          wcount !== '0 || ovf !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_idle: hold=%b rd=%h rdy=%b busy=%b wcount=%0d ovf=%b, want 1 00000000 0 0 0 0",
                 cpu_hold, cpu_rd, ld_ready, busy, wcount, ovf);
      end
    end
  endtask

  task automatic test_basic();
    int c;
    prog.delete();
    prog.push_back(32'h20080005);
    prog.push_back(32'h20090007);
    prog.push_back(32'h01095020);
    prog.push_back(32'hAC0A0010);
    run_load(100, -1, c);
    tests++;
    if (c != 68) begin
      fails++;
      $display("[TB] FAIL basic_latency: %0d cycles, want 68", c);
    end
    check_run("basic");
  endtask

  task automatic test_overflow();
    int c;
    rand_prog(70);
    run_load(100, -1, c);
    tests++;
    if (c != D + 70) begin
      fails++;
      $display("[TB] FAIL ovf_latency: %0d cycles, want %0d", c, D + 70);
    end
    check_run("ovf");
  endtask

  task automatic test_stall();
    int c;
    rand_prog(10);
    run_load(50, -1, c);
    check_run("stall");
  endtask

  task automatic test_back_to_back();
    int c;
    rand_prog(12);
    run_load(100, -1, c);
    check_run("prog_a");
    rand_prog(3);
    run_load(100, -1, c);
    check_run("prog_b");
  endtask

  task automatic test_reset_mid_clear();
    int c;
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    repeat (29) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    #1;
    tests++;
    if (cpu_hold !== 1'b1 || busy !== 1'b0 || ld_ready !== 1'b0 || wcount !== '0 || ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_clear_reset: hold=%b busy=%b rdy=%b wcount=%0d ovf=%b, want 1 0 0 0 0",
               cpu_hold, busy, ld_ready, wcount, ovf);
    end
    rand_prog(8);
    run_load(100, D + 2, c);
    tests++;
    if (c != D + 8) begin
      fails++;
      $display("[TB] FAIL restart_latency: %0d cycles, want %0d", c, D + 8);
    end
    check_run("restart");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
